// File: rtl/dcache_mem_bridge_if.sv
// MIG-style DDR user-interface bundle (app_*) between the bridge and the memory controller.
// master = command/data issuer (the bridge), slave = the DDR controller side.
interface dcache_mem_bridge_if #(
    parameter int unsigned AWIDTH = 28
);
    logic [AWIDTH-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy;
    logic [127:0]      app_wdf_data;
    logic [15:0]       app_wdf_mask;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_wdf_rdy;
    logic [127:0]      app_rd_data;
    logic              app_rd_data_valid;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/dcache_mem_bridge.sv
// Queues D-cache line write-backs and fills, then issues them one at a time, in order,
// to a MIG-style DDR user interface. All outputs are registered.
module dcache_mem_bridge #(
    parameter int unsigned AWIDTH = 28,
    parameter int unsigned QDEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_calib_complete,
    input  logic                dcw_start_rq,
    input  logic [31:0]         dcw_in_addr,
    input  logic [15:0]         dcw_in_mask,
    input  logic [127:0]        dcw_in_data,
    output logic                dcw_finish_wresp,
    input  logic                dcr_start_rq,
    input  logic [31:0]         dcr_rin_addr,
    output logic                rqfull_1,
    output logic [127:0]        rdat_m_data,
    output logic                rdat_m_valid,
    output logic                finish_mrd,
    output logic                ovf_err,
    dcache_mem_bridge_if.master app
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        StIdle, StWcmd, StWresp, StRcmd, StRwait, StRdat, StRfin
    } state_e;

    // ---------------- request queue ----------------
    logic          q_wr   [QDEPTH];
    logic [27:0]   q_addr [QDEPTH];
    logic [15:0]   q_mask [QDEPTH];
    logic [127:0]  q_data [QDEPTH];

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, rd_slot;
    logic [CW-1:0] count_q, count_d, free_slots;
    logic          acc_w, acc_r, drop, pop;
    logic          rqfull_q, ovf_q;

    logic          head_wr;
    logic [27:0]   head_addr;
    logic [15:0]   head_mask;
    logic [127:0]  head_data;

    always_comb begin
        free_slots = CW'(QDEPTH) - count_q;
        acc_w      = dcw_start_rq && (free_slots != '0);
        // the write claims a slot first, so the read needs one more free slot
        acc_r      = dcr_start_rq && (free_slots > CW'(acc_w));
        drop       = (dcw_start_rq && !acc_w) || (dcr_start_rq && !acc_r);
        rd_slot    = wptr_q + PW'(acc_w);
        wptr_d     = wptr_q + PW'(acc_w) + PW'(acc_r);
        rptr_d     = rptr_q + PW'(pop);
        count_d    = count_q + CW'(acc_w) + CW'(acc_r) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (acc_w) begin
            q_wr[wptr_q]   <= 1'b1;
            q_addr[wptr_q] <= dcw_in_addr[31:4];
            q_mask[wptr_q] <= dcw_in_mask;
            q_data[wptr_q] <= dcw_in_data;
        end
        if (acc_r) begin
            q_wr[rd_slot]   <= 1'b0;
            q_addr[rd_slot] <= dcr_rin_addr[31:4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rqfull_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rqfull_q <= (count_d >= CW'(QDEPTH - 1));
            ovf_q    <= ovf_q | drop;
        end
    end

    assign head_wr   = q_wr[rptr_q];
    assign head_addr = q_addr[rptr_q];
    assign head_mask = q_mask[rptr_q];
    assign head_data = q_data[rptr_q];

    // ---------------- transaction FSM ----------------
    state_e            state_q, state_d;
    logic              cmd_done_q, cmd_done_d, dat_done_q, dat_done_d;
    logic              app_en_q, app_en_d, wren_q, wren_d;
    logic [2:0]        app_cmd_q, app_cmd_d;
    logic [AWIDTH-1:0] app_addr_q, app_addr_d;
    logic [127:0]      wdf_data_q, wdf_data_d;
    logic [15:0]       wdf_mask_q, wdf_mask_d;
    logic              wresp_q, wresp_d, rvalid_q, rvalid_d, mrd_q, mrd_d;
    logic [127:0]      rdata_q, rdata_d;
    logic              cmd_hs, dat_hs;

    assign cmd_hs = app_en_q && app.app_rdy;
    assign dat_hs = wren_q && app.app_wdf_rdy;

    always_comb begin
        state_d    = state_q;
        cmd_done_d = cmd_done_q;
        dat_done_d = dat_done_q;
        app_en_d   = app_en_q;
        wren_d     = wren_q;
        app_cmd_d  = app_cmd_q;
        app_addr_d = app_addr_q;
        wdf_data_d = wdf_data_q;
        wdf_mask_d = wdf_mask_q;
        rdata_d    = rdata_q;
        wresp_d    = 1'b0;
        rvalid_d   = 1'b0;
        mrd_d      = 1'b0;
        pop        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if ((count_q != '0) && init_calib_complete) begin
                    app_addr_d = {head_addr[AWIDTH-4:0], 3'b000};
                    app_en_d   = 1'b1;
                    cmd_done_d = 1'b0;
                    dat_done_d = 1'b0;
                    if (head_wr) begin
                        state_d    = StWcmd;
                        app_cmd_d  = 3'b000;
                        wren_d     = 1'b1;
                        wdf_data_d = head_data;
                        wdf_mask_d = ~head_mask;
                    end else begin
                        state_d   = StRcmd;
                        app_cmd_d = 3'b001;
                    end
                end
            end
            StWcmd: begin
                // command and data channels complete independently
                if (cmd_hs) begin
                    app_en_d   = 1'b0;
                    cmd_done_d = 1'b1;
                end
                if (dat_hs) begin
                    wren_d     = 1'b0;
                    dat_done_d = 1'b1;
                end
                if ((cmd_done_q || cmd_hs) && (dat_done_q || dat_hs)) begin
                    state_d = StWresp;
                end
            end
            StWresp: begin
                wresp_d = 1'b1;
                pop     = 1'b1;
                state_d = StIdle;
            end
            StRcmd: begin
                if (cmd_hs) begin
                    app_en_d = 1'b0;
                    state_d  = StRwait;
                end
            end
            StRwait: begin
                if (app.app_rd_data_valid) begin
                    rdata_d = app.app_rd_data;
                    state_d = StRdat;
                end
            end
            StRdat: begin
                rvalid_d = 1'b1;
                state_d  = StRfin;
            end
            StRfin: begin
                mrd_d   = 1'b1;
                pop     = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cmd_done_q <= 1'b0;
            dat_done_q <= 1'b0;
            app_en_q   <= 1'b0;
            wren_q     <= 1'b0;
            app_cmd_q  <= '0;
            app_addr_q <= '0;
            wdf_data_q <= '0;
            wdf_mask_q <= '0;
            rdata_q    <= '0;
            wresp_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            mrd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_done_q <= cmd_done_d;
            dat_done_q <= dat_done_d;
            app_en_q   <= app_en_d;
            wren_q     <= wren_d;
            app_cmd_q  <= app_cmd_d;
            app_addr_q <= app_addr_d;
            wdf_data_q <= wdf_data_d;
            wdf_mask_q <= wdf_mask_d;
            rdata_q    <= rdata_d;
            wresp_q    <= wresp_d;
            rvalid_q   <= rvalid_d;
            mrd_q      <= mrd_d;
        end
    end

    assign app.app_en       = app_en_q;
    assign app.app_cmd      = app_cmd_q;
    assign app.app_addr     = app_addr_q;
    assign app.app_wdf_data = wdf_data_q;
    assign app.app_wdf_mask = wdf_mask_q;
    assign app.app_wdf_wren = wren_q;
    assign app.app_wdf_end  = wren_q;

    assign dcw_finish_wresp = wresp_q;
    assign rdat_m_data      = rdata_q;
    assign rdat_m_valid     = rvalid_q;
    assign finish_mrd       = mrd_q;
    assign rqfull_1         = rqfull_q;
    assign ovf_err          = ovf_q;

    // line-offset bits and address bits above the DDR range are intentionally dropped
    logic unused_bits;
    assign unused_bits = ^{dcw_in_addr[3:0], dcr_rin_addr[3:0], head_addr[27:AWIDTH-3]};

endmodule

// File: doc/dcache_mem_bridge.md
Name: dcache_mem_bridge

Overview:
- Sits directly downstream of cpu_top's D-cache line interface (dcw_*/dcr_*/rdat_m_*).
- Queues cache-line write-back and line-fill requests, then issues them one at a time to a MIG-style DDR user interface (app_*).
- Returns a write-response pulse for each write, and read data plus a finish pulse for each read.
- Strictly in-order, single outstanding DDR transaction.

Parameters:
- AWIDTH, 28: width of app_addr (DDR user-interface address, 16-bit units).
- QDEPTH, 4: request queue depth in entries (power of two, >=2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- init_calib_complete  input  1  DDR ready; no dispatch while 0
- dcw_start_rq  input  1  write-line request strobe (1 cycle)
- dcw_in_addr  input  32  write byte address; bits[3:0] ignored
- dcw_in_mask  input  16  byte enables, 1 = write byte
- dcw_in_data  input  128  write line data
- dcw_finish_wresp  output  1  write complete pulse
- dcr_start_rq  input  1  read-line request strobe (1 cycle)
- dcr_rin_addr  input  32  read byte address; bits[3:0] ignored
- rqfull_1  output  1  queue nearly full; upstream must not request
- rdat_m_data  output  128  read line data
- rdat_m_valid  output  1  rdat_m_data valid pulse
- finish_mrd  output  1  read complete pulse
- ovf_err  output  1  sticky: request dropped on full queue
- app_addr  output  AWIDTH  DDR address
- app_cmd  output  3  000 write, 001 read
- app_en  output  1  command valid
- app_rdy  input  1  command accepted when app_en&app_rdy
- app_wdf_data  output  128  write data
- app_wdf_mask  output  16  1 = byte NOT written
- app_wdf_wren  output  1  write data valid
- app_wdf_end  output  1  equals app_wdf_wren (single-beat line)
- app_wdf_rdy  input  1  data accepted when app_wdf_wren&app_wdf_rdy
- app_rd_data  input  128  DDR read data
- app_rd_data_valid  input  1  app_rd_data valid

Behaviour:
- Reset: asynchronous, active-low. Clock: single clock clk.
- Reset values: all outputs 0, queue empty, FSM in IDLE.
- Reset mid-transaction abandons it without any pulse.
- Queue entries hold {type, addr[31:4], mask, data}; mask/data are don't-care for reads.
- Push:
  - dcw_start_rq pushes a write; dcr_start_rq pushes a read.
  - If both in the same cycle, the write is enqueued first, then the read (2 pushes).
  - A push with no free slot is dropped and sets ovf_err (cleared only by reset).
  - For two simultaneous pushes with one free slot, the write is kept and the read dropped.
- rqfull_1 = (count >= QDEPTH-1), registered from the next-state count.
- Address mapping: app_addr = {addr[AWIDTH:4], 3'b000}.
- Data/mask mapping: app_wdf_mask = ~mask; app_wdf_data = data.
- FSM states: IDLE, WCMD, WRESP, RCMD, RWAIT, RDAT, RFIN.
  - IDLE: if queue non-empty and init_calib_complete, go to WCMD or RCMD by head type.
  - WCMD: app_en=1, app_cmd=000, app_wdf_wren=app_wdf_end=1.
    - Track cmd_done and dat_done flags independently; drop each signal once its handshake completes.
    - When both are done (same cycle allowed), go to WRESP.
  - WRESP: dcw_finish_wresp=1 for one cycle; pop head; go to IDLE.
  - RCMD: app_en=1, app_cmd=001; on app_rdy go to RWAIT.
  - RWAIT: on app_rd_data_valid, latch app_rd_data into rdat_m_data; go to RDAT.
  - RDAT: rdat_m_valid=1 for one cycle; go to RFIN.
  - RFIN: finish_mrd=1 for one cycle; pop head; go to IDLE.
- app_* outputs are registered. Command fields remain stable while app_en=1.
- Latency: with the queue empty, in IDLE and DDR ready, a start_rq at cycle 0 gives app_en=1 at cycle 2.
- The queue may push and pop in the same cycle; count is unchanged.
- rdat_m_data holds its last value until the next read latch.
- app_rd_data_valid outside RWAIT is ignored.
- init_calib_complete dropping affects only the IDLE dispatch decision.

Test Plan:
- Single write: addr 0x0000_1230, mask 0x000F, data 0x...DEADBEEF, app_rdy=app_wdf_rdy=1 -> app_en at cycle 2, app_addr=0x123<<3 (0x918), app_wdf_mask=0xFFF0, dcw_finish_wresp pulse at cycle 4.
- Write with app_rdy delayed 3 cycles and app_wdf_rdy immediate -> app_wdf_wren drops after 1 cycle, app_en held 4 cycles, exactly one finish pulse.
- Read addr 0x40, DDR returns 0x0123...CDEF 5 cycles after the command -> rdat_m_valid pulse with that data, finish_mrd on the following cycle, no dcw_finish_wresp.
- Simultaneous dcw_start_rq and dcr_start_rq -> write is issued before the read; responses arrive in order.
- 5 writes back-to-back with app_rdy=0 and QDEPTH=4 -> rqfull_1=1 after the 3rd push, 5th push dropped, ovf_err=1, exactly 4 finish pulses after app_rdy is released.
- init_calib_complete=0 with a queued read -> no app_en; dispatch occurs 1 cycle after calib rises. Reset asserted in RWAIT -> all outputs 0 and queue empty.
